// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified memory between the instruction-fetch (IF)
// and data-memory (DM) pipeline stages. Each access runs IDLE -> ACCESS
// (MEM_LATENCY cycles with the memory port held stable) -> RESP (one-cycle
// ack). DM wins simultaneous requests unless IF has been passed over
// STARVE_LIMIT times in a row, in which case IF is forced through.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   if_req/if_addr        IF request (level, held until if_ack) and address
//   if_ack/if_rdata       IF one-cycle ack pulse and fetched data
//   dm_req/dm_we/dm_addr/dm_wdata
//                         DM request (level, held until dm_ack), direction,
//                         address and write data
//   dm_ack/dm_rdata       DM one-cycle ack pulse and read data (0 on writes)
//   mem_en/mem_we/mem_addr/mem_wdata
//                         registered memory port, stable through ACCESS
//   mem_rdata             memory read data, sampled at the end of ACCESS
//   stall_if/stall_dm     request pending and not yet acked (combinational)
//   busy                  arbiter is not IDLE
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W       = 64,
   parameter int DATA_W       = 64,
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_ack,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_if,
   output logic              stall_dm,
   output logic              busy
);

   localparam int LAT_W = $clog2(MEM_LATENCY + 1);
   localparam int STV_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LATENCY);
   localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   state_t           state_reg;
   logic [LAT_W-1:0] lat_cnt_reg;
   logic [STV_W-1:0] starve_cnt_reg;
   logic             owner_dm_reg;

   // IF is forced only when both request and IF has lost STARVE_LIMIT
   // consecutive arbitrations; a zero limit disables forcing entirely.
   logic force_if;
   logic grant_dm;

   assign force_if = (STARVE_LIMIT != 0) && (starve_cnt_reg >= STV_MAX);
   assign grant_dm = dm_req && !(if_req && force_if);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         lat_cnt_reg    <= '0;
         starve_cnt_reg <= '0;
         owner_dm_reg   <= 1'b0;
         if_ack         <= 1'b0;
         dm_ack         <= 1'b0;
         if_rdata       <= '0;
         dm_rdata       <= '0;
         mem_en         <= 1'b0;
         mem_we         <= 1'b0;
         mem_addr       <= '0;
         mem_wdata      <= '0;
      end else begin
         // Acks are single-cycle pulses; only the ACCESS->RESP edge raises one.
         if_ack <= 1'b0;
         dm_ack <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (if_req || dm_req) begin
                  state_reg   <= ACCESS;
                  lat_cnt_reg <= LAT_W'(1);
                  mem_en      <= 1'b1;
                  if (grant_dm) begin
                     owner_dm_reg <= 1'b1;
                     mem_we       <= dm_we;
                     mem_addr     <= dm_addr;
                     mem_wdata    <= dm_wdata;
                     // Count only grants that actually passed IF over.
                     if (if_req && (starve_cnt_reg < STV_MAX))
                        starve_cnt_reg <= starve_cnt_reg + 1'b1;
                  end else begin
                     owner_dm_reg   <= 1'b0;
                     mem_we         <= 1'b0;
                     mem_addr       <= if_addr;
                     mem_wdata      <= '0;
                     starve_cnt_reg <= '0;
                  end
               end
            end

            ACCESS: begin
               if (lat_cnt_reg == LAT_LAST) begin
                  state_reg   <= RESP;
                  lat_cnt_reg <= '0;
                  mem_en      <= 1'b0;
                  mem_we      <= 1'b0;
                  if (owner_dm_reg) begin
                     dm_ack   <= 1'b1;
                     // mem_we still holds the latched direction this cycle.
                     dm_rdata <= mem_we ? '0 : mem_rdata;
                  end else begin
                     if_ack   <= 1'b1;
                     if_rdata <= mem_rdata;
                  end
               end else begin
                  lat_cnt_reg <= lat_cnt_reg + 1'b1;
               end
            end

            // No arbitration here: the just-acked requester may still hold
            // req this cycle and must not be granted a second access.
            RESP: begin
               state_reg <= IDLE;
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign stall_if = if_req & ~if_ack;
   assign stall_dm = dm_req & ~dm_ack;
   assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Bench for mem_port_arbiter (MEM_LATENCY=2, STARVE_LIMIT=4). A small memory
// model answers the memory port; every issued request pushes its expected
// owner and data onto a scoreboard queue, and an ack monitor pops and compares.
// Single-request transactions come from a vector table; arbitration,
// starvation, reset and request-drop cases are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int AW = 64;
   localparam int DW = 64;
   localparam logic [63:0] DFLT_XOR = 64'h5A5A_0000_0000_0000;

   logic          clk;
   logic          reset;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_ack;
   logic [DW-1:0] if_rdata;
   logic          dm_req;
   logic          dm_we;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic          dm_ack;
   logic [DW-1:0] dm_rdata;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          stall_if;
   logic          stall_dm;
   logic          busy;

   mem_port_arbiter #(
      .ADDR_W(AW),
      .DATA_W(DW),
      .MEM_LATENCY(2),
      .STARVE_LIMIT(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .if_req(if_req),
      .if_addr(if_addr),
      .if_ack(if_ack),
      .if_rdata(if_rdata),
      .dm_req(dm_req),
      .dm_we(dm_we),
      .dm_addr(dm_addr),
      .dm_wdata(dm_wdata),
      .dm_ack(dm_ack),
      .dm_rdata(dm_rdata),
      .mem_en(mem_en),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .stall_if(stall_if),
      .stall_dm(stall_dm),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------- memory
   // 128-word model indexed by addr[9:3]; unwritten words read addr^DFLT_XOR.
   logic [63:0] mem_arr [128];
   logic        mem_vld [128];
   logic [6:0]  mem_idx;

   assign mem_idx = mem_addr[9:3];

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 128; i++) mem_vld[i] <= 1'b0;
         mem_vld[8] <= 1'b1;
         mem_arr[8] <= 64'h0000_0000_D503_201F;
      end else if (mem_en && mem_we) begin
         mem_arr[mem_idx] <= mem_wdata;
         mem_vld[mem_idx] <= 1'b1;
      end
   end

   always_comb begin
      mem_rdata = '0;
      if (mem_en)
         mem_rdata = mem_vld[mem_idx] ? mem_arr[mem_idx] : (mem_addr ^ DFLT_XOR);
   end

   // ---------------------------------------------------------------- checks
   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %0s actual=%h required=%h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------- scoreboard
   typedef struct {
      logic        dm;
      logic [63:0] data;
   } sb_t;

   sb_t sb_q[$];
   sb_t mon_e;

   always @(negedge clk) begin
      if (!reset && (if_ack || dm_ack)) begin
         chk("ack_exclusive", {63'd0, if_ack & dm_ack}, 64'd0);
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ack if_ack=%0b dm_ack=%0b", if_ack, dm_ack);
         end else begin
            mon_e = sb_q.pop_front();
            chk("ack_owner", {63'd0, dm_ack}, {63'd0, mon_e.dm});
            chk("ack_data", mon_e.dm ? dm_rdata : if_rdata, mon_e.data);
            $display("txn %0s ack data=%h expected=%h", mon_e.dm ? "DM" : "IF",
                     mon_e.dm ? dm_rdata : if_rdata, mon_e.data);
         end
      end
   end

   // ---------------------------------------------------------------- vectors
   typedef struct {
      logic        dm;
      logic        we;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] exp;
   } vec_t;

   vec_t        vecs [6];
   logic [63:0] last_if;
   logic [63:0] last_dm;

   // One isolated access starting in an IDLE cycle (called just after a
   // rising edge); returns just after the edge that ends the ack cycle.
   task automatic run_single(input vec_t v, input string tag);
      if (v.dm) begin
         dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
      end
      sb_q.push_back('{dm: v.dm, data: v.exp});
      @(negedge clk);   // cycle 0
      chk({tag, "_c0_stall"}, {63'd0, v.dm ? stall_dm : stall_if}, 64'd1);
      chk({tag, "_c0_mem_en"}, {63'd0, mem_en}, 64'd0);
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk);
         chk({tag, "_acc_mem_en"}, {63'd0, mem_en}, 64'd1);
         chk({tag, "_acc_mem_addr"}, mem_addr, v.addr);
         chk({tag, "_acc_mem_we"}, {63'd0, mem_we}, {63'd0, v.we});
         if (v.we) chk({tag, "_acc_mem_wdata"}, mem_wdata, v.wdata);
         chk({tag, "_acc_stall"}, {63'd0, v.dm ? stall_dm : stall_if}, 64'd1);
         chk({tag, "_acc_no_ack"}, {62'd0, if_ack, dm_ack}, 64'd0);
      end
      @(negedge clk);   // cycle 3: response
      chk({tag, "_resp_ack"}, {62'd0, if_ack, dm_ack}, v.dm ? 64'd1 : 64'd2);
      chk({tag, "_resp_mem_en"}, {63'd0, mem_en}, 64'd0);
      chk({tag, "_resp_busy"}, {63'd0, busy}, 64'd1);
      chk({tag, "_resp_stall"}, {63'd0, v.dm ? stall_dm : stall_if}, 64'd0);
      chk({tag, "_other_rdata_hold"}, v.dm ? if_rdata : dm_rdata, v.dm ? last_if : last_dm);
      if (v.dm) last_dm = v.exp; else last_if = v.exp;
      @(posedge clk); #1;
      if (v.dm) dm_req = 1'b0; else if_req = 1'b0;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- main
   initial begin
      logic own_if;

      vecs[0] = '{dm: 1'b0, we: 1'b0, addr: 64'h40,  wdata: 64'h0,                 exp: 64'h0000_0000_D503_201F};
      vecs[1] = '{dm: 1'b1, we: 1'b1, addr: 64'h80,  wdata: 64'h1234,              exp: 64'h0};
      vecs[2] = '{dm: 1'b1, we: 1'b0, addr: 64'h80,  wdata: 64'h0,                 exp: 64'h1234};
      vecs[3] = '{dm: 1'b0, we: 1'b0, addr: 64'h88,  wdata: 64'h0,                 exp: 64'h5A5A_0000_0000_0088};
      vecs[4] = '{dm: 1'b1, we: 1'b1, addr: 64'h100, wdata: 64'hDEAD_BEEF_CAFE_F00D, exp: 64'h0};
      vecs[5] = '{dm: 1'b0, we: 1'b0, addr: 64'h100, wdata: 64'h0,                 exp: 64'hDEAD_BEEF_CAFE_F00D};

      reset = 1'b1;
      if_req = 1'b0; if_addr = '0;
      dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
      last_if = '0; last_dm = '0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_mem_en_we", {62'd0, mem_en, mem_we}, 64'd0);
      chk("rst_mem_addr", mem_addr, 64'd0);
      chk("rst_mem_wdata", mem_wdata, 64'd0);
      chk("rst_acks", {62'd0, if_ack, dm_ack}, 64'd0);
      chk("rst_if_rdata", if_rdata, 64'd0);
      chk("rst_dm_rdata", dm_rdata, 64'd0);
      @(posedge clk); #1;

      // Table of isolated accesses.
      for (int i = 0; i < 6; i++) run_single(vecs[i], $sformatf("vec%0d", i));

      // Simultaneous requests: DM first, IF granted in the following IDLE.
      if_req = 1'b1; if_addr = 64'h40;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h80;
      sb_q.push_back('{dm: 1'b1, data: 64'h1234});
      sb_q.push_back('{dm: 1'b0, data: 64'h0000_0000_D503_201F});
      @(negedge clk);                    // c0
      @(negedge clk);                    // c1
      chk("sim_c1_mem_addr", mem_addr, 64'h80);
      @(negedge clk);                    // c2
      @(negedge clk);                    // c3
      chk("sim_c3_dm_ack", {62'd0, if_ack, dm_ack}, 64'd1);
      chk("sim_c3_stall_if", {63'd0, stall_if}, 64'd1);
      @(posedge clk); #1 dm_req = 1'b0;
      @(negedge clk);                    // c4: IDLE, no DM re-grant
      chk("sim_c4_mem_en", {63'd0, mem_en}, 64'd0);
      chk("sim_c4_busy", {63'd0, busy}, 64'd0);
      @(negedge clk);                    // c5
      chk("sim_c5_mem_en", {63'd0, mem_en}, 64'd1);
      chk("sim_c5_mem_addr", mem_addr, 64'h40);
      @(negedge clk);                    // c6
      chk("sim_c6_no_ack", {62'd0, if_ack, dm_ack}, 64'd0);
      @(negedge clk);                    // c7
      chk("sim_c7_if_ack", {62'd0, if_ack, dm_ack}, 64'd2);
      @(posedge clk); #1 if_req = 1'b0;
      last_if = 64'h0000_0000_D503_201F;
      last_dm = 64'h1234;

      // Starvation: both requesting continuously -> D D D D I D D D D I.
      if_req = 1'b1; if_addr = 64'h48;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h90;
      for (int k = 0; k < 10; k++) begin
         own_if = (k == 4) || (k == 9);
         sb_q.push_back('{dm: !own_if, data: own_if ? 64'h5A5A_0000_0000_0048
                                                   : 64'h5A5A_0000_0000_0090});
         @(negedge clk);
         @(negedge clk);
         chk($sformatf("starve%0d_mem_addr", k), mem_addr, own_if ? 64'h48 : 64'h90);
         @(negedge clk);
         @(negedge clk);
         chk($sformatf("starve%0d_ack", k), {62'd0, if_ack, dm_ack}, own_if ? 64'd2 : 64'd1);
         @(posedge clk);
      end
      #1;
      if_req = 1'b0; dm_req = 1'b0;

      // Reset during ACCESS cycle 1 of a DM read: abandoned, no ack.
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'hA0;
      @(negedge clk);                    // c0
      @(negedge clk);                    // c1
      chk("rma_c1_mem_en", {63'd0, mem_en}, 64'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; dm_req = 1'b0;
      @(negedge clk);                    // c2
      chk("rma_c2_mem_en", {63'd0, mem_en}, 64'd0);
      chk("rma_c2_busy", {63'd0, busy}, 64'd0);
      chk("rma_c2_dm_ack", {63'd0, dm_ack}, 64'd0);
      chk("rma_c2_dm_rdata", dm_rdata, 64'd0);
      @(negedge clk);                    // c3
      chk("rma_c3_dm_ack", {63'd0, dm_ack}, 64'd0);
      @(posedge clk); #1;
      last_if = '0; last_dm = '0;
      run_single(vecs[0], "post_rst");

      // IF drops req mid-access: latched address still served and acked.
      if_req = 1'b1; if_addr = 64'h58;
      sb_q.push_back('{dm: 1'b0, data: 64'h5A5A_0000_0000_0058});
      @(negedge clk);                    // c0
      @(posedge clk); #1;
      if_req = 1'b0; if_addr = 64'h60;
      @(negedge clk);                    // c1
      chk("drop_c1_mem_en", {63'd0, mem_en}, 64'd1);
      chk("drop_c1_mem_addr", mem_addr, 64'h58);
      @(negedge clk);                    // c2
      chk("drop_c2_mem_addr", mem_addr, 64'h58);
      @(negedge clk);                    // c3
      chk("drop_c3_if_ack", {62'd0, if_ack, dm_ack}, 64'd2);
      @(posedge clk); #1;

      repeat (3) @(negedge clk);
      chk("sb_drained", 64'(sb_q.size()), 64'd0);
      chk("final_busy", {63'd0, busy}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the pipeline's instruction-fetch stage (IF) and data-memory stage (DM).
- Sequences each access over a fixed memory latency and returns read data with a one-cycle ack pulse.
- Drives stall outputs to the pipeline_CPU hazard logic.
- DM has priority; a starvation counter guarantees IF forward progress.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width.
- MEM_LATENCY, 2, cycles mem_en/address are held before mem_rdata is sampled (legal range ≥1).
- STARVE_LIMIT, 4, consecutive DM grants with IF waiting before IF is forced; 0 disables forcing.

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  IF access request, level; held until if_ack
- if_addr  in  ADDR_W  IF address
- if_ack  out  1  one-cycle pulse; if_rdata valid this cycle
- if_rdata  out  DATA_W  fetched data
- dm_req  in  1  DM access request, level; held until dm_ack
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_W  DM address
- dm_wdata  in  DATA_W  DM write data
- dm_ack  out  1  one-cycle pulse; dm_rdata valid this cycle
- dm_rdata  out  DATA_W  DM read data (0 for writes)
- mem_en  out  1  memory access active
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid in last access cycle
- stall_if  out  1  if_req & ~if_ack (combinational)
- stall_dm  out  1  dm_req & ~dm_ack (combinational)
- busy  out  1  state ≠ IDLE

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset (synchronous, any state): state=IDLE, latency counter=0, starve counter=0.
  - All registered outputs 0: acks, rdata, mem_en, mem_we, mem_addr, mem_wdata.
  - An in-flight access is abandoned with no ack. mem_en drops in the cycle after reset is sampled.
- IDLE, arbitration (cycle 0):
  - if_req only → grant IF.
  - dm_req only → grant DM.
  - Both asserted → grant DM, unless STARVE_LIMIT≠0 and starve_cnt ≥ STARVE_LIMIT, then grant IF.
  - On grant: latch owner, addr, we (IF: forced 0), wdata; go to ACCESS.
  - No request → stay IDLE.
- Starve counter:
  - Incremented (saturating at STARVE_LIMIT) on a DM grant while if_req=1.
  - Cleared on any IF grant.
  - Unchanged otherwise.
- ACCESS, cycles 1..MEM_LATENCY:
  - mem_en=1; mem_addr, mem_we, mem_wdata driven from latched values and stable throughout.
  - Latency counter counts 1..MEM_LATENCY.
  - At the edge ending cycle MEM_LATENCY: capture mem_rdata into the owner's rdata register (writes load 0), then go to RESP.
- RESP, cycle MEM_LATENCY+1:
  - Owner's ack=1 for exactly this cycle; mem_en=0.
  - No arbitration in RESP; the acked requester's still-high req must not cause a re-grant. Next state is IDLE.
- Throughput: one access per MEM_LATENCY+2 cycles.
- Request-to-ack latency: MEM_LATENCY+1 cycles.
- The non-owning rdata register holds its last value.
- Input changes during ACCESS: ignored, because the latched copies drive memory. A requester dropping req mid-access still receives its ack.
- if_ack and dm_ack are never high in the same cycle.
- A request arriving during ACCESS or RESP waits and is arbitrated in the next IDLE cycle.

Test Plan (MEM_LATENCY=2, STARVE_LIMIT=4):
- Reset, then IF read:
  - Stimulus: reset 2 cycles, then if_req=1, if_addr=0x40, memory returns 0xD503201F.
  - Required: mem_en high cycles 1–2 with mem_addr=0x40; if_ack pulse at cycle 3 with if_rdata=0xD503201F; stall_if=1 cycles 0–2.
- DM write:
  - Stimulus: dm_req=1, dm_we=1, dm_addr=0x80, dm_wdata=0x1234.
  - Required: mem_we=1 and mem_wdata=0x1234 in cycles 1–2; dm_ack at cycle 3; dm_rdata=0.
- Simultaneous requests:
  - Stimulus: if_req and dm_req asserted together in cycle 0.
  - Required: DM acked cycle 3; IF granted in IDLE cycle 4 and acked cycle 7; no double grant of DM in its RESP cycle.
- Starvation:
  - Stimulus: if_req held high; dm_req re-asserted immediately after every ack.
  - Required: exactly 4 DM accesses, then an IF grant; starve_cnt returns to 0.
- Reset mid-access:
  - Stimulus: reset asserted in ACCESS cycle 1 of a DM read.
  - Required: no dm_ack; mem_en=0 the next cycle; busy=0; a following request behaves as in the first scenario.
- Request drop:
  - Stimulus: if_req deasserted during ACCESS.
  - Required: if_ack still pulses at cycle 3 with the latched-address data.
